// File: rtl/alu_output_registers.sv
// alu_output_registers: selects one functional-unit result by one-hot op select,
// computes status flags and queues result+flags in a DEPTH-entry valid/ready FIFO;
// also owns the accumulator fed back to the input stage.
// Ports: clk, rst (sync, active-high); unit_bus/op_s/div_zero/acc_en/in_valid/in_ready
// producer side; out_data/out_flags/out_valid/out_ready consumer side; acc_val,
// count (occupancy), err_sticky status.
// Optional: define ALU_OUT_PARITY_EN to store even parity of the data in out_flags[3].
module alu_output_registers #(
  parameter int N     = 16,
  parameter int OPS   = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [OPS*N-1:0]         unit_bus,
  input  logic [OPS-1:0]           op_s,
  input  logic                     div_zero,
  input  logic                     acc_en,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [N-1:0]             out_data,
  output logic [3:0]               out_flags,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N-1:0]             acc_val,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err_sticky
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
`ifdef ALU_OUT_PARITY_EN
  localparam int FW = 4;
`else
  localparam int FW = 3;
`endif
  logic [N+FW-1:0] mem_q [DEPTH];
  logic [N+FW-1:0] head;
  logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    acc_q, acc_d, sel, dat;
  logic [FW-1:0]   flg;
  logic            err_q, err_d, sel_err, err, push, pop;
  always_comb begin
    sel = '0;
    for (int k = 0; k < OPS; k++) sel |= {N{op_s[k]}} & unit_bus[k*N +: N];
  end
  // x & (x-1) is nonzero exactly when more than one bit is set
  assign sel_err = ~|op_s | |(op_s & (op_s - OPS'(1)));
  assign err     = sel_err | div_zero;
  // forcing data to 0 on error makes zero=1 and negative=0 fall out naturally
  assign dat     = err ? '0 : sel;
`ifdef ALU_OUT_PARITY_EN
  assign flg = {^dat, err, dat[N-1], ~|dat};
`else
  assign flg = {err, dat[N-1], ~|dat};
`endif
  assign in_ready  = cnt_q != CW'(DEPTH);
  assign out_valid = cnt_q != '0;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  always_comb begin
    wr_d  = push ? wr_q + AW'(1) : wr_q;
    rd_d  = pop ? rd_q + AW'(1) : rd_q;
    cnt_d = (push & ~pop) ? cnt_q + CW'(1) : (pop & ~push) ? cnt_q - CW'(1) : cnt_q;
    acc_d = (push & acc_en & ~err) ? sel : acc_q;
    err_d = err_q | (push & err);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      acc_q <= '0;
      err_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      err_q <= err_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_q] <= {flg, dat};
  end
  // empty FIFO presents zeros so reset/idle outputs are defined
  assign head       = out_valid ? mem_q[rd_q] : '0;
  assign out_data   = head[N-1:0];
  assign out_flags  = 4'(head[N +: FW]);
  assign acc_val    = acc_q;
  assign count      = cnt_q;
  assign err_sticky = err_q;
endmodule

// File: tb/tb_alu_output_registers.sv
// tb_alu_output_registers: scoreboard bench for alu_output_registers.
module tb_alu_output_registers;
  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] unit_bus;
  logic [7:0]   op_s;
  logic         div_zero, acc_en, in_valid, out_ready;
  logic         in_ready, out_valid, err_sticky;
  logic [15:0]  out_data, acc_val;
  logic [3:0]   out_flags;
  logic [2:0]   count;
  int checks = 0;
  int failures = 0;
  logic [19:0]  sb[$];
  logic [15:0]  m_acc;
  logic         m_err;
  alu_output_registers dut (
    .clk(clk), .rst(rst), .unit_bus(unit_bus), .op_s(op_s), .div_zero(div_zero),
    .acc_en(acc_en), .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_flags(out_flags), .out_valid(out_valid), .out_ready(out_ready),
    .acc_val(acc_val), .count(count), .err_sticky(err_sticky)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [19:0] expect_entry(input logic [127:0] bus, input logic [7:0] ops, input logic dz);
    logic [15:0] d;
    logic        e;
    logic        p;
    int          idx;
    idx = 0;
    for (int k = 0; k < 8; k++) if (ops[k]) idx = k;
    e = ($countones(ops) != 1) || dz;
    d = e ? 16'h0 : bus[idx*16 +: 16];
`ifdef ALU_OUT_PARITY_EN
    p = ^d;
`else
    p = 1'b0;
`endif
    return {p, e, d[15], d == 16'h0, d};
  endfunction
  // inputs are already driven; check state at negedge, advance model across posedge
  task automatic cyc();
    logic [19:0] ent;
    logic        pu, po;
    check("count", 32'(count), 32'(sb.size()));
    check("in_ready", 32'(in_ready), 32'(sb.size() != 4));
    check("out_valid", 32'(out_valid), 32'(sb.size() != 0));
    check("acc_val", 32'(acc_val), 32'(m_acc));
    check("err_sticky", 32'(err_sticky), 32'(m_err));
    if (sb.size() != 0) begin
      check("out_data", 32'(out_data), 32'(sb[0][15:0]));
      check("out_flags", 32'(out_flags), 32'(sb[0][19:16]));
    end else begin
      check("out_data_idle", 32'(out_data), 32'h0);
      check("out_flags_idle", 32'(out_flags), 32'h0);
    end
    ent = expect_entry(unit_bus, op_s, div_zero);
    pu = in_valid && sb.size() < 4;
    po = out_ready && sb.size() != 0;
    @(posedge clk);
    if (rst) begin
      sb.delete();
      m_acc = 16'h0;
      m_err = 1'b0;
    end else begin
      if (po) void'(sb.pop_front());
      if (pu) begin
        sb.push_back(ent);
        if (acc_en && !ent[18]) m_acc = ent[15:0];
        if (ent[18]) m_err = 1'b1;
      end
    end
    @(negedge clk);
  endtask
  task automatic drive(input int lane, input logic [15:0] v, input logic [7:0] ops,
                       input logic dz, input logic ae, input logic iv, input logic ordy);
    for (int k = 0; k < 8; k++) unit_bus[k*16 +: 16] = 16'hA000 + 16'(k);
    unit_bus[lane*16 +: 16] = v;
    op_s = ops; div_zero = dz; acc_en = ae; in_valid = iv; out_ready = ordy;
    cyc();
  endtask
  task automatic idle(input logic ordy);
    drive(0, 16'h0, 8'h01, 1'b0, 1'b0, 1'b0, ordy);
  endtask
  initial begin
    m_acc = 16'h0; m_err = 1'b0;
    rst = 1'b1;
    unit_bus = '0; op_s = '0; div_zero = 0; acc_en = 0; in_valid = 0; out_ready = 0;
    @(negedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    idle(1'b0);
    // single op on lane 2
    drive(2, 16'h8001, 8'b00000100, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(1'b0);
    check("lane2_data", 32'(out_data), 32'h8001);
    idle(1'b1);
    // fill to full, then offer while popping one
    for (int i = 1; i <= 4; i++) drive(i - 1, 16'(i), 8'(1 << (i - 1)), 1'b0, 1'b1, 1'b1, 1'b0);
    check("full_ready", 32'(in_ready), 32'h0);
    drive(4, 16'd5, 8'b00010000, 1'b0, 1'b1, 1'b1, 1'b1);
    idle(1'b0);
    check("after_full_head", 32'(out_data), 32'd2);
    for (int i = 0; i < 3; i++) idle(1'b1);
    // simultaneous push/pop across pointer wrap
    drive(5, 16'd7, 8'b00100000, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(6, 16'd8, 8'b01000000, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(7, 16'd9, 8'b10000000, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(1'b1); idle(1'b1); idle(1'b0);
    // errors: multi-hot select, then divide by zero
    drive(0, 16'h1234, 8'b00000011, 1'b0, 1'b1, 1'b1, 1'b0);
    drive(3, 16'h5555, 8'b00001000, 1'b1, 1'b1, 1'b1, 1'b0);
    drive(1, 16'h0000, 8'b00000010, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(1'b1); idle(1'b1); idle(1'b1); idle(1'b0);
    // reset mid-operation with push and pop requested
    for (int i = 0; i < 3; i++) drive(i, 16'h0F00 + 16'(i), 8'(1 << i), 1'b0, 1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    drive(4, 16'h7777, 8'b00010000, 1'b0, 1'b1, 1'b1, 1'b1);
    rst = 1'b0;
    idle(1'b0);
    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      int          ln;
      logic [7:0]  ops;
      ln  = $urandom_range(0, 7);
      ops = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'(1 << ln);
      drive(ln, 16'($urandom), ops, $urandom_range(0, 15) == 0, 1'($urandom),
            1'($urandom), 1'($urandom));
    end
    for (int i = 0; i < 5; i++) idle(1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
